// File: rtl/uart_autobaud_ctrl_pkg.sv
// Shared UART auto-baud definitions: FSM states, error codes, sync pattern constants.
package uart_autobaud_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_MEASURE = 3'd2,
      S_CHECK   = 3'd3,
      S_LOCKED  = 3'd4
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_SHAPE   = 2'b10;
   localparam logic [1:0] ERR_RANGE   = 2'b11;

   // 0x55 sent LSB first gives falling edges at bit times 0, 2, 4, 6 and 8.
   localparam int SYNC_EDGES = 5;

endpackage

// File: rtl/uart_autobaud_ctrl_if.sv
// Control/status bundle between the rx pin side, the sequencer and the baud generator.
interface uart_autobaud_ctrl_if #(parameter int MAX_BITS = 11);
   logic                rx;
   logic                start;
   logic [MAX_BITS-1:0] final_value;
   logic                baud_en;
   logic                busy;
   logic                locked;
   logic                err;
   logic [1:0]          err_code;

   modport master (output rx, start,
                   input  final_value, baud_en, busy, locked, err, err_code);
   modport slave  (input  rx, start,
                   output final_value, baud_en, busy, locked, err, err_code);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw rx line plus a one-cycle falling-edge strobe.
module uart_rx_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic rx,
   output logic fall
);
   logic [1:0] meta;
   logic       prev;

   // Line idles high, so all stages reset to 1 to avoid a false edge after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 2'b11;
         prev <= 1'b1;
      end else begin
         meta <= {meta[0], rx};
         prev <= meta[1];
      end
   end

   assign fall = prev & ~meta[1];
endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: times a 0x55 sync character and loads the baud generator terminal count.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | default/last-good final_value in use, baud generator running
// S_ARMED   | generator stopped, waiting for the start-bit falling edge
// S_MEASURE | timing the four edge-to-edge intervals of the sync char
// S_CHECK   | rounding the 8-bit-period sum into final_value, range test
// S_LOCKED  | measured final_value in use, baud generator running
module uart_autobaud_ctrl
   import uart_autobaud_ctrl_pkg::*;
#(
   parameter int MAX_BITS   = 11,
   parameter int CNT_W      = 20,
   parameter int DEFAULT_FV = 650,
   parameter int MIN_FV     = 1
) (
   input logic                 clk,
   input logic                 reset_n,
   uart_autobaud_ctrl_if.slave bus
);
   localparam int SUM_W = CNT_W + 2;

   state_t              state;
   logic                fall;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W:0]      ref_iv;
   logic [SUM_W-1:0]    sum;
   logic [2:0]          edges;
   logic [MAX_BITS-1:0] fv_q;
   logic                baud_en_q, busy_q, locked_q, err_q;
   logic [1:0]          code_q;

   logic [CNT_W:0]      interval, lo_bound, quarter;
   logic [CNT_W+1:0]    hi_bound;
   logic                shape_ok;
   logic [SUM_W:0]      rounded;
   logic [31:0]         quot;
   logic                fv_ok;
   logic                err_hit;
   logic [1:0]          err_sel;

   uart_rx_sync u_rx_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .rx      (bus.rx),
      .fall    (fall)
   );

   // The counter reads P-1 when the next edge arrives P cycles later, hence the +1.
   assign interval = {1'b0, cnt} + (CNT_W+1)'(1);
   assign quarter  = ref_iv >> 2;
   assign lo_bound = ref_iv - quarter;
   assign hi_bound = {1'b0, ref_iv} + {1'b0, quarter};
   assign shape_ok = (interval >= lo_bound) && ({1'b0, interval} <= hi_bound);

   // sum spans 8 bit periods = 128 oversample ticks; round to nearest, then minus one.
   // Testing quot instead of quot-1 keeps the range check free of underflow.
   assign rounded = {1'b0, sum} + (SUM_W+1)'(64);
   assign quot    = 32'(rounded[SUM_W:7]);
   assign fv_ok   = (quot >= 32'(MIN_FV + 1)) && (quot <= 32'(2 ** MAX_BITS));

   // Error detection; an edge arriving on the saturation cycle takes priority over timeout.
   always_comb begin
      err_hit = 1'b0;
      err_sel = ERR_NONE;
      if (state == S_MEASURE) begin
         if (fall) begin
            if (edges != 3'd1 && !shape_ok) begin
               err_hit = 1'b1;
               err_sel = ERR_SHAPE;
            end
         end else if (cnt == '1) begin
            err_hit = 1'b1;
            err_sel = ERR_TIMEOUT;
         end
      end else if (state == S_CHECK && !fv_ok) begin
         err_hit = 1'b1;
         err_sel = ERR_RANGE;
      end
   end

   // Sequencer with registered outputs; final_value only moves on a passing CHECK.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         ref_iv    <= '0;
         sum       <= '0;
         edges     <= '0;
         fv_q      <= MAX_BITS'(DEFAULT_FV);
         baud_en_q <= 1'b1;
         busy_q    <= 1'b0;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= ERR_NONE;
      end else begin
         err_q <= 1'b0;
         if (err_hit) begin
            state     <= S_IDLE;
            err_q     <= 1'b1;
            code_q    <= err_sel;
            locked_q  <= 1'b0;
            baud_en_q <= 1'b1;
            busy_q    <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_LOCKED: begin
                  // err_q high means the error pulse is on the bus this cycle.
                  if (bus.start && !err_q) begin
                     state     <= S_ARMED;
                     code_q    <= ERR_NONE;
                     locked_q  <= 1'b0;
                     baud_en_q <= 1'b0;
                     busy_q    <= 1'b1;
                  end
               end
               S_ARMED: begin
                  if (fall) begin
                     state <= S_MEASURE;
                     cnt   <= '0;
                     sum   <= '0;
                     edges <= 3'd1;
                  end
               end
               S_MEASURE: begin
                  if (fall) begin
                     sum   <= sum + SUM_W'(interval);
                     cnt   <= '0;
                     edges <= edges + 3'd1;
                     if (edges == 3'd1) ref_iv <= interval;
                     if (edges == 3'(SYNC_EDGES - 1)) state <= S_CHECK;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               S_CHECK: begin
                  state     <= S_LOCKED;
                  fv_q      <= MAX_BITS'(quot - 32'd1);
                  locked_q  <= 1'b1;
                  baud_en_q <= 1'b1;
                  busy_q    <= 1'b0;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.final_value = fv_q;
   assign bus.baud_en     = baud_en_q;
   assign bus.busy        = busy_q;
   assign bus.locked      = locked_q;
   assign bus.err         = err_q;
   assign bus.err_code    = code_q;
endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Bench for uart_autobaud_ctrl: two instances run in parallel. dut_a uses the full
// 20-bit counter for the real-rate frames; dut_b uses a 12-bit counter so that the
// timeout case fits in a short run. Each lock or error event is checked against a
// queue of expected outcomes pushed when the stimulus is launched.
module tb_uart_autobaud_ctrl;
   import uart_autobaud_ctrl_pkg::*;

   typedef struct packed {
      logic [1:0]  code;
      logic [10:0] fv;
      logic        locked;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   logic lk_a_q = 1'b0, err_a_q = 1'b0;
   logic lk_b_q = 1'b0, err_b_q = 1'b0;

   always #5 clk = ~clk;

   uart_autobaud_ctrl_if #(.MAX_BITS(11)) ifa ();
   uart_autobaud_ctrl_if #(.MAX_BITS(11)) ifb ();

   uart_autobaud_ctrl #(.MAX_BITS(11), .CNT_W(20), .DEFAULT_FV(650), .MIN_FV(1)) dut_a (
      .clk(clk), .reset_n(rst_a), .bus(ifa));
   uart_autobaud_ctrl #(.MAX_BITS(11), .CNT_W(12), .DEFAULT_FV(650), .MIN_FV(1)) dut_b (
      .clk(clk), .reset_n(rst_b), .bus(ifb));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_rx(input int inst, input logic v);
      if (inst == 0) ifa.rx = v; else ifb.rx = v;
   endtask

   task automatic pulse_start(input int inst);
      @(negedge clk);
      if (inst == 0) ifa.start = 1'b1; else ifb.start = 1'b1;
      @(negedge clk);
      if (inst == 0) ifa.start = 1'b0; else ifb.start = 1'b0;
   endtask

   // Five falling edges separated by the four given intervals (low half, high half),
   // then a short low tail and return to idle.
   task automatic send_falls(input int inst, input int i1, input int i2, input int i3, input int i4);
      int iv[4];
      iv = '{i1, i2, i3, i4};
      foreach (iv[k]) begin
         set_rx(inst, 1'b0);
         repeat (iv[k] / 2) @(negedge clk);
         set_rx(inst, 1'b1);
         repeat (iv[k] - iv[k] / 2) @(negedge clk);
      end
      set_rx(inst, 1'b0);
      repeat (16) @(negedge clk);
      set_rx(inst, 1'b1);
      repeat (16) @(negedge clk);
   endtask

   task automatic wait_drain(input int inst, input int limit);
      int n = 0;
      while (((inst == 0) ? q_a.size() : q_b.size()) != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk((inst == 0) ? "a_drain" : "b_drain", (inst == 0) ? q_a.size() : q_b.size(), 0);
   endtask

   // Scoreboard for dut_a: compare on every error pulse or rising locked.
   always @(negedge clk) begin
      exp_t e;
      if (err_a_q) chk("a_err_width", 32'(ifa.err), 0);
      if (ifa.err || (ifa.locked && !lk_a_q)) begin
         chk("a_sb_pending", 32'(q_a.size() != 0), 1);
         if (q_a.size() != 0) begin
            e = q_a.pop_front();
            chk("a_err_code", 32'(ifa.err_code), 32'(e.code));
            chk("a_final_value", 32'(ifa.final_value), 32'(e.fv));
            chk("a_locked", 32'(ifa.locked), 32'(e.locked));
         end
      end
      lk_a_q  <= ifa.locked;
      err_a_q <= ifa.err;
   end

   // Scoreboard for dut_b.
   always @(negedge clk) begin
      exp_t e;
      if (err_b_q) chk("b_err_width", 32'(ifb.err), 0);
      if (ifb.err || (ifb.locked && !lk_b_q)) begin
         chk("b_sb_pending", 32'(q_b.size() != 0), 1);
         if (q_b.size() != 0) begin
            e = q_b.pop_front();
            chk("b_err_code", 32'(ifb.err_code), 32'(e.code));
            chk("b_final_value", 32'(ifb.final_value), 32'(e.fv));
            chk("b_locked", 32'(ifb.locked), 32'(e.locked));
         end
      end
      lk_b_q  <= ifb.locked;
      err_b_q <= ifb.err;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      ifa.rx = 1'b1; ifa.start = 1'b0;
      ifb.rx = 1'b1; ifb.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_fv", 32'(ifa.final_value), 650);
      chk("rst_baud_en", 32'(ifa.baud_en), 1);
      chk("rst_busy", 32'(ifa.busy), 0);
      chk("rst_locked", 32'(ifa.locked), 0);
      chk("rst_err", 32'(ifa.err), 0);
      chk("rst_err_code", 32'(ifa.err_code), 0);
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_fv", 32'(ifa.final_value), 650);
      chk("idle_baud_en", 32'(ifa.baud_en), 1);
      chk("idle_locked", 32'(ifa.locked), 0);

      fork
         begin : seq_a
            pulse_start(0);
            chk("a_arm_busy", 32'(ifa.busy), 1);
            chk("a_arm_baud_en", 32'(ifa.baud_en), 0);
            q_a.push_back('{code: ERR_NONE, fv: 11'd53, locked: 1'b1});
            send_falls(0, 1736, 1736, 1736, 1736);
            wait_drain(0, 200);
            chk("a_lock_baud_en", 32'(ifa.baud_en), 1);
            chk("a_lock_busy", 32'(ifa.busy), 0);
            pulse_start(0);
            chk("a_rearm_locked", 32'(ifa.locked), 0);
            chk("a_rearm_baud_en", 32'(ifa.baud_en), 0);
            chk("a_rearm_fv_held", 32'(ifa.final_value), 53);
            q_a.push_back('{code: ERR_NONE, fv: 11'd650, locked: 1'b1});
            send_falls(0, 20834, 20834, 20834, 20834);
            wait_drain(0, 200);
            chk("a_9600_baud_en", 32'(ifa.baud_en), 1);
         end
         begin : seq_b
            pulse_start(1);
            q_b.push_back('{code: ERR_NONE, fv: 11'd26, locked: 1'b1});
            send_falls(1, 868, 868, 868, 868);
            wait_drain(1, 200);

            pulse_start(1);
            q_b.push_back('{code: ERR_SHAPE, fv: 11'd26, locked: 1'b0});
            send_falls(1, 1736, 1736, 2604, 1736);
            wait_drain(1, 200);
            chk("b_shape_baud_en", 32'(ifb.baud_en), 1);

            pulse_start(1);
            chk("b_start_clears_code", 32'(ifb.err_code), 0);
            q_b.push_back('{code: ERR_RANGE, fv: 11'd26, locked: 1'b0});
            send_falls(1, 20, 20, 20, 20);
            wait_drain(1, 200);

            pulse_start(1);
            q_b.push_back('{code: ERR_TIMEOUT, fv: 11'd26, locked: 1'b0});
            set_rx(1, 1'b0);
            wait_drain(1, 6000);
            set_rx(1, 1'b1);
            repeat (4) @(negedge clk);
            chk("b_timeout_busy", 32'(ifb.busy), 0);
            chk("b_timeout_baud_en", 32'(ifb.baud_en), 1);

            pulse_start(1);
            set_rx(1, 1'b0);
            repeat (50) @(negedge clk);
            chk("b_mid_busy", 32'(ifb.busy), 1);
            rst_b = 1'b0;
            #1;
            chk("b_areset_fv", 32'(ifb.final_value), 650);
            chk("b_areset_baud_en", 32'(ifb.baud_en), 1);
            chk("b_areset_busy", 32'(ifb.busy), 0);
            chk("b_areset_locked", 32'(ifb.locked), 0);
            chk("b_areset_err", 32'(ifb.err), 0);
            chk("b_areset_code", 32'(ifb.err_code), 0);
            set_rx(1, 1'b1);
            @(negedge clk);
            rst_b = 1'b1;
         end
      join

      repeat (4) @(negedge clk);
      chk("a_sb_left", q_a.size(), 0);
      chk("b_sb_left", q_b.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/uart_autobaud_ctrl.md
Name: uart_autobaud_ctrl

Overview:
- Auto-baud controller that configures the UART baud-tick generator.
- Measures a received 0x55 sync character on the rx line and computes the 16x-oversample terminal count, final_value = f_clk/(16*BR) - 1.
- Enables the baud generator only while a valid configuration is in effect.
- Sits between the rx pin and the baud generator's Final_Value/enable inputs.

Parameters:
- MAX_BITS, 11, width of final_value; must match the baud generator.
- CNT_W, 20, width of the edge-interval measurement counter.
- DEFAULT_FV, 650, reset/fallback final_value (100 MHz, 9600 baud).
- MIN_FV, 1, smallest accepted computed final_value.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx  in  1  raw serial line, idle high, asynchronous to clk
- start  in  1  one-cycle pulse that arms a measurement
- final_value  out  MAX_BITS  terminal count to the baud generator
- baud_en  out  1  enable to the baud generator
- busy  out  1  measurement in progress
- locked  out  1  final_value holds a measured value
- err  out  1  one-cycle error pulse
- err_code  out  2  00 none, 01 timeout, 10 shape, 11 range; held until next start

Behaviour:
- Reset values: final_value=DEFAULT_FV, baud_en=1, busy=0, locked=0, err=0, err_code=00, state IDLE.
- rx input path:
  - 2-flop synchronizer, then a previous-sample register.
  - fall = prev & ~sync.
  - Latency is fixed, so it cancels out of all interval measurements.
- Sync pattern 0x55, LSB first: falling edges occur at bit times 0, 2, 4, 6, 8. The measured span E1 to E5 equals 8 bit periods.
- States:
  - IDLE: baud_en=1. start -> ARMED, clears err_code and locked.
  - ARMED: baud_en=0, busy=1. First fall -> MEASURE; interval counter cleared, edge count=1.
  - MEASURE: counter increments each cycle. On each fall:
    - Add the interval to a sum register of CNT_W+2 bits.
    - The first interval is stored as ref.
    - Each later interval must lie in [ref - ref/4, ref + ref/4], otherwise error shape.
    - Counter restarts from 0.
    - After the 4th interval -> CHECK.
  - Timeout in MEASURE: counter reaches 2^CNT_W-1 with no fall in that cycle -> error timeout. If a fall coincides with saturation, the edge wins.
  - CHECK (1 cycle): fv = ((sum + 64) >> 7) - 1, computed with no underflow wrap.
    - fv < MIN_FV or fv > 2^MAX_BITS-1 -> error range.
    - Otherwise final_value <= fv, locked <= 1 -> LOCKED.
  - LOCKED: baud_en=1, busy=0. start re-arms (-> ARMED, locked=0).
  - Error path: err=1 for one cycle, err_code set, final_value left unchanged, locked=0 -> IDLE.
- final_value changes only in CHECK-pass and on reset; it never changes while baud_en=1.
- start while busy is ignored. start on the same cycle as an error pulse is ignored.
- A rising edge or glitch during ARMED does not count as a measurement.
- Async reset mid-measurement returns all registers to reset values immediately.
- All arithmetic is unsigned. The ±ref/4 bounds are computed with shift and add only; no divider or multiplier.

Decomposition:
- Shared uart package holds:
  - state encoding localparams (IDLE, ARMED, MEASURE, CHECK, LOCKED);
  - err_code constants;
  - the SYNC_EDGES=5 constant.
- One natural sub-module: uart_rx_sync, the 2-flop synchronizer plus falling-edge detector, reusable by the UART receiver.

Test Plan:
- Reset, then idle rx: final_value=650, baud_en=1, locked=0.
- start, then 0x55 at 10417 clk/bit (9600 baud, 100 MHz): sum=83336, final_value=650, locked=1, baud_en low during measurement and high after.
- start, then 0x55 at 868 clk/bit: sum=6944, final_value=53, locked=1. A second start plus 9600-baud frame returns 650.
- start, then first two intervals 1736, third interval 2604: err pulse, err_code=10, final_value unchanged, locked=0.
- start, then 0x55 at 10 clk/bit: fv=0 < MIN_FV, err_code=11, final_value unchanged.
- start, one falling edge, rx held low for 2^20 cycles: err_code=01, state IDLE. Also assert reset_n low mid-MEASURE: all outputs return to reset values immediately.
